output_collector: RTL and testbench

//  Downstream stage of the multiplier/accumulator/output-stage chain. It captures the
//  NUM_FEATURES quantised results that chain emits and tracks their validity through the
//  ce-gated pipeline. It packs PACK_FACTOR result vectors into one wide word and buffers

---
 rtl/linear_pkg.sv | 16 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/output_collector.sv | 111 +++++++++++
 tb/tb_output_collector.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/linear_pkg.sv
// Shared types and helpers for the multiplier/accumulator/output-stage chain.
package linear_pkg;

    localparam int unsigned MAX_PIPE_LATENCY = 64;
    localparam int unsigned DEF_PRECISION    = 8;
    localparam int unsigned DEF_NUM_FEATURES = 2;

    typedef logic [DEF_NUM_FEATURES-1:0][DEF_PRECISION-1:0] res_vec_t;

    function automatic int unsigned out_word_width(input int unsigned pack_factor,
                                                   input int unsigned num_features,
                                                   input int unsigned precision);
        return pack_factor * num_features * precision;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word fall-through FIFO; a push into a full FIFO is accepted only with a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    always_comb begin
        full    = (count == CNT_W'(DEPTH));
        empty   = (count == '0);
        rd_en   = pop & ~empty;
        wr_en   = push & (~full | rd_en);
        // head is forced to zero when empty so reset presents a clean output word
        rd_data = empty ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/output_collector.sv
// Captures pipeline results by validity tag, packs them into wide words and
// buffers the words for a valid/ready consumer with upstream backpressure.
module output_collector
    import linear_pkg::*;
#(
    parameter int unsigned PRECISION       = 8,
    parameter int unsigned NUM_FEATURES    = 2,
    parameter int unsigned PIPE_LATENCY    = 6,
    parameter int unsigned PACK_FACTOR     = 4,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned WORDS_PER_FRAME = 8,
    localparam int unsigned W = out_word_width(PACK_FACTOR, NUM_FEATURES, PRECISION)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ce,
    input  logic                              in_valid,
    input  logic [NUM_FEATURES*PRECISION-1:0] res_in,
    input  logic                              flush,
    output logic                              ce_allow,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [W-1:0]                      m_data,
    output logic                              m_last,
    output logic                              overflow
);

    localparam int unsigned VW     = NUM_FEATURES * PRECISION;
    localparam int unsigned SLOT_W = (PACK_FACTOR > 1) ? $clog2(PACK_FACTOR) : 1;
    localparam int unsigned WORD_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    logic [PIPE_LATENCY-1:0]         tag;
    logic [SLOT_W-1:0]               slot_cnt;
    logic [WORD_W-1:0]               word_cnt;
    logic [PACK_FACTOR-1:0][VW-1:0]  pack_reg;
    logic [PACK_FACTOR-1:0][VW-1:0]  pack_next;
    logic                            flush_pend;
    logic                            capture;
    logic                            slot_last;
    logic                            word_last;
    logic                            flush_push;
    logic                            push;
    logic                            pop;
    logic [W:0]                      push_data;
    logic [W:0]                      head;
    logic [CNT_W-1:0]                fifo_count;
    logic                            fifo_full;
    logic                            fifo_empty;

    always_comb begin
        capture    = ce & tag[PIPE_LATENCY-1];
        slot_last  = (slot_cnt == SLOT_W'(PACK_FACTOR - 1));
        word_last  = (word_cnt == WORD_W'(WORDS_PER_FRAME - 1));
        // a flush waits for a capture-free cycle so a concurrent capture lands first
        flush_push = flush_pend & ~capture & (slot_cnt != '0);
        pack_next  = pack_reg;
        if (capture) pack_next[slot_cnt] = res_in;
        push       = (capture & slot_last) | flush_push;
        push_data  = {word_last, pack_next};
        m_valid    = ~fifo_empty;
        pop        = m_valid & m_ready;
        m_data     = head[W-1:0];
        m_last     = head[W];
        ce_allow   = (fifo_count < CNT_W'(FIFO_DEPTH - 1)) | pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag        <= '0;
            slot_cnt   <= '0;
            word_cnt   <= '0;
            pack_reg   <= '0;
            flush_pend <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (ce) tag <= (tag << 1) | PIPE_LATENCY'(in_valid);

            if (push) begin
                pack_reg <= '0;
                slot_cnt <= '0;
            end else if (capture) begin
                pack_reg <= pack_next;
                slot_cnt <= slot_cnt + 1'b1;
            end

            if (push) word_cnt <= word_last ? '0 : word_cnt + 1'b1;

            if (flush)                               flush_pend <= 1'b1;
            else if (flush_push || slot_cnt == '0)   flush_pend <= 1'b0;

            if (push & fifo_full & ~pop) overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (push_data),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_output_collector.sv
// Directed bench for output_collector: latency, stall, backpressure, framing, flush, reset, overflow.
module tb_output_collector;

    localparam int unsigned PL = 6;
    localparam int unsigned W  = 64;

    logic          clk = 1'b0;
    logic          rst, ce, in_valid, flush, m_ready;
    logic [15:0]   res_in;
    logic          ce_allow, m_valid, m_last, overflow;
    logic [W-1:0]  m_data;

    int            total = 0;
    int            bad   = 0;
    int            vpipe [PL];
    int            next_idx;
    logic [W:0]    got_q [$];
    logic          saw_block;

    always #5 clk = ~clk;

    output_collector #(
        .PRECISION       (8),
        .NUM_FEATURES    (2),
        .PIPE_LATENCY    (PL),
        .PACK_FACTOR     (4),
        .FIFO_DEPTH      (16),
        .WORDS_PER_FRAME (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .in_valid (in_valid),
        .res_in   (res_in),
        .flush    (flush),
        .ce_allow (ce_allow),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .overflow (overflow)
    );

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) got_q.push_back({m_last, m_data});
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] vec(input int v);
        return {v[7:0], v[7:0]};
    endfunction

    function automatic logic [W:0] exp_word(input int base, input int n, input bit last);
        logic [W:0] w;
        w = '0;
        for (int j = 0; j < n; j++) w[j*16 +: 16] = vec(base + j);
        w[W] = last;
        return w;
    endfunction

    // upstream model: sample indices travel PL ce-cycles before appearing on res_in
    task automatic tick();
        bit ce_s, iv_s;
        ce_s = ce;
        iv_s = in_valid;
        @(posedge clk);
        if (ce_s) begin
            for (int i = PL - 1; i > 0; i--) vpipe[i] = vpipe[i-1];
            vpipe[0] = iv_s ? next_idx : -1;
            if (iv_s) next_idx++;
        end
        #1;
        res_in = (vpipe[PL-1] >= 0) ? vec(vpipe[PL-1]) : 16'hdead;
    endtask

    task automatic do_reset();
        rst = 1'b1; ce = 1'b0; in_valid = 1'b0; flush = 1'b0; m_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < PL; i++) vpipe[i] = -1;
        next_idx = 0;
        got_q.delete();
        res_in = 16'hdead;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_m_valid"},  m_valid,  1'b0);
        check({tag, "_m_data"},   m_data,   64'h0);
        check({tag, "_m_last"},   m_last,   1'b0);
        check({tag, "_overflow"}, overflow, 1'b0);
        check({tag, "_ce_allow"}, ce_allow, 1'b1);
    endtask

    task automatic check_stream(input string tag, input int n);
        check({tag, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), got_q[i], exp_word(4 * i, 4, (i % 8) == 7));
    endtask

    task automatic stream_plain(input int nvec, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            ce = 1'b1;
            in_valid = (next_idx < nvec);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d expected finish", $time);
        $fatal(1);
    end

    initial begin
        res_in = 16'hdead;
        do_reset();
        check_reset_vals("rst0");

        // 1: continuous stream, first word visible at cycle 10
        m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            ce = 1'b1;
            in_valid = (next_idx < 8);
            tick();
            if (c == 8) check("t1_valid_c9", m_valid, 1'b0);
            if (c == 9) begin
                check("t1_valid_c10", m_valid, 1'b1);
                check("t1_data_c10",  m_data,  64'h0303020201010000);
                check("t1_last_c10",  m_last,  1'b0);
            end
        end
        check_stream("t1", 2);

        // 2: ce stalled for 5 cycles shifts everything by 5 cycles
        do_reset();
        m_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            ce = !(c >= 3 && c < 8);
            in_valid = (next_idx < 8);
            tick();
            if (c == 13) check("t2_valid_c14", m_valid, 1'b0);
            if (c == 14) check("t2_valid_c15", m_valid, 1'b1);
        end
        check_stream("t2", 2);

        // 3: backpressure with ce gated by ce_allow
        do_reset();
        saw_block = 1'b0;
        for (int c = 0; c < 150; c++) begin
            in_valid = (next_idx < 64);
            ce = ce_allow;
            if (!ce_allow) saw_block = 1'b1;
            tick();
        end
        check("t3_blocked",    saw_block, 1'b1);
        check("t3_ce_allow",   ce_allow,  1'b0);
        check("t3_held_valid", m_valid,   1'b1);
        check("t3_held_data",  m_data,    exp_word(0, 4, 1'b0));
        check("t3_no_pops",    got_q.size(), 0);
        m_ready = 1'b1;
        #1;
        for (int c = 0; c < 300 && got_q.size() < 16; c++) begin
            in_valid = (next_idx < 64);
            ce = ce_allow;
            tick();
        end
        check_stream("t3", 16);
        check("t3_overflow", overflow, 1'b0);

        // 4: frame marker on word 7 only
        do_reset();
        m_ready = 1'b1;
        stream_plain(32, 52);
        check_stream("t4", 8);

        // 5: flush alongside a capture, then an idle flush, then a fresh word
        do_reset();
        m_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            ce = 1'b1;
            in_valid = (c < 6) || (c >= 30 && c < 34);
            flush = (c == 11) || (c == 25);
            tick();
            if (c == 28) check("t5_idle_flush", got_q.size(), 2);
        end
        flush = 1'b0;
        check("t5_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("t5_w0", got_q[0], exp_word(0, 4, 1'b0));
            check("t5_w1", got_q[1], exp_word(4, 2, 1'b0));
            check("t5_w2", got_q[2], exp_word(6, 4, 1'b0));
        end

        // 6: reset after 3 captures into the third word
        do_reset();
        for (int c = 0; c < 17; c++) begin
            ce = 1'b1;
            in_valid = (c < 11);
            tick();
        end
        check("t6_pre_valid", m_valid, 1'b1);
        do_reset();
        check_reset_vals("t6_rst");
        m_ready = 1'b1;
        stream_plain(32, 52);
        check_stream("t6", 8);

        // 7: upstream ignoring ce_allow overruns a full FIFO
        do_reset();
        for (int c = 0; c < 90; c++) begin
            ce = 1'b1;
            in_valid = (next_idx < 68);
            tick();
            if (c == 70) begin
                check("t7_full_ovf", overflow, 1'b0);
                check("t7_full_ce",  ce_allow, 1'b0);
            end
        end
        check("t7_overflow", overflow, 1'b1);
        m_ready = 1'b1;
        stream_plain(0, 20);
        check_stream("t7", 16);
        check("t7_sticky", overflow, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
